// File: rtl/iob_reg_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin holding-register arbiter.
package iob_reg_rr_arbiter_pkg;

    // Holding register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Width of a requester index: clog2(n), but never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Value loaded into the data and id registers on reset.
    localparam int unsigned DATA_RST_VAL = 0;

endpackage

// File: rtl/iob_reg_rr_arbiter_if.sv
// Requester-side and consumer-side handshake bundle for iob_reg_rr_arbiter.
interface iob_reg_rr_arbiter_if
    import iob_reg_rr_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 21
);
    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic                    out_valid_o;
    logic [DATA_W-1:0]       out_data_o;
    logic [ID_W-1:0]         out_id_o;
    logic                    out_ready_i;
    logic                    busy_o;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_id_o, busy_o
    );

    // Producer/consumer side.
    modport master (
        output req_valid_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_id_o, busy_o
    );
endinterface

// File: rtl/iob_reg_rr_arbiter_pick.sv
// Rotate-priority picker: first valid index at or after ptr_i, wrapping at N_REQ.
module iob_rr_pick
    import iob_reg_rr_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Scan N_REQ positions starting at ptr_i; the explicit wrap keeps
    // non-power-of-2 requester counts from indexing past N_REQ-1.
    always_comb begin
        int k;
        // NOTE: every output gets a default before the loop, otherwise a
        // no-valid cycle would leave them unassigned and infer latches.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!any_o && valid_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/iob_reg_rr_arbiter.sv
// Round-robin arbiter feeding one shared holding register with a valid/ready output.
module iob_reg_rr_arbiter
    import iob_reg_rr_arbiter_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 21,
    localparam int ID_W   = id_width(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 cke_i,
    iob_reg_rr_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q;
    logic [ID_W-1:0]   id_q;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_valid;
    logic              load;
    logic              en;

    iob_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .valid_i (bus.req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (any_valid)
    );

    // The register may take a new word when empty or draining this cycle;
    // gating with arst_n_i keeps every ready low while reset is held.
    assign load = cke_i & arst_n_i & ((state_q == ST_EMPTY) | bus.out_ready_i);
    assign en   = load & any_valid;

    // Occupancy and round-robin pointer next state; both hold unless loading.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (load) begin
            state_d = any_valid ? ST_FULL : ST_EMPTY;
        end
        if (en) begin
            ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Enable-gated holding register: data and id only change on a real grant.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_q <= DATA_W'(DATA_RST_VAL);
            id_q   <= '0;
        end else if (en) begin
            data_q <= bus.req_data_i[grant_idx*DATA_W +: DATA_W];
            id_q   <= grant_idx;
        end
    end

    assign bus.req_ready_o = load ? grant : '0;
    assign bus.out_valid_o = (state_q == ST_FULL);
    assign bus.out_data_o  = data_q;
    assign bus.out_id_o    = id_q;
    assign bus.busy_o      = (state_q == ST_FULL) | (|bus.req_valid_i);

endmodule

// File: tb/tb_iob_reg_rr_arbiter.sv
// Directed self-checking bench for iob_reg_rr_arbiter (N_REQ=4 and N_REQ=3 builds).
module tb_iob_reg_rr_arbiter;

    localparam int DW = 21;

    logic clk = 1'b0;
    logic arst_n;
    logic cke;
    int   checks = 0;
    int   errors = 0;

    iob_reg_rr_arbiter_if #(.N_REQ(4), .DATA_W(DW)) b4 ();
    iob_reg_rr_arbiter_if #(.N_REQ(3), .DATA_W(DW)) b3 ();

    iob_reg_rr_arbiter #(.N_REQ(4), .DATA_W(DW)) dut4 (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .bus      (b4)
    );

    iob_reg_rr_arbiter #(.N_REQ(3), .DATA_W(DW)) dut3 (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .bus      (b3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int k, input logic [DW-1:0] v);
        b4.req_data_i[k*DW +: DW] = v;
    endtask

    task automatic set3(input int k, input logic [DW-1:0] v);
        b3.req_data_i[k*DW +: DW] = v;
    endtask

    task automatic out4(input string tag, input logic v, input logic [DW-1:0] d, input logic [1:0] id);
        check({tag, "_valid"}, 64'(b4.out_valid_o), 64'(v));
        check({tag, "_data"},  64'(b4.out_data_o),  64'(d));
        check({tag, "_id"},    64'(b4.out_id_o),    64'(id));
    endtask

    initial begin
        arst_n         = 1'b0;
        cke            = 1'b1;
        b4.req_valid_i = '0;
        b4.req_data_i  = '0;
        b4.out_ready_i = 1'b0;
        b3.req_valid_i = '0;
        b3.req_data_i  = '0;
        b3.out_ready_i = 1'b0;

        // Reset state.
        #1;
        out4("rst", 1'b0, '0, 2'd0);
        check("rst_ready", 64'(b4.req_ready_o), 64'h0);
        check("rst_busy",  64'(b4.busy_o),      64'h0);
        tick();
        tick();
        arst_n = 1'b1;

        // All four valid, consumer always ready: ids 0,1,2,3,0 back to back.
        b4.req_valid_i = 4'b1111;
        for (int k = 0; k < 4; k++) set4(k, DW'(32'h10 + k));
        b4.out_ready_i = 1'b1;
        #1;
        check("rr_ready0", 64'(b4.req_ready_o), 64'b0001);
        check("rr_busy",   64'(b4.busy_o),      64'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            out4($sformatf("rr%0d", i), 1'b1, DW'(32'h10 + (i % 4)), 2'(i % 4));
        end
        // Requests stop: register drains, data/id keep their last values.
        b4.req_valid_i = '0;
        tick();
        out4("drain", 1'b0, DW'(32'h10), 2'd0);
        check("drain_busy", 64'(b4.busy_o), 64'h0);

        // Only requester 2, consumer stalled (ptr=1 so search wraps 1->2).
        b4.req_valid_i = 4'b0100;
        set4(2, DW'(32'h1ABCD));
        b4.out_ready_i = 1'b0;
        #1;
        check("r2_ready", 64'(b4.req_ready_o), 64'b0100);
        tick();
        out4("r2_acc", 1'b1, DW'(32'h1ABCD), 2'd2);
        // New requesters 0 and 3 arrive while the consumer stalls.
        b4.req_valid_i = 4'b1001;
        set4(0, DW'(32'h20));
        set4(3, DW'(32'h23));
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold%0d_ready", i), 64'(b4.req_ready_o), 64'h0);
            tick();
            out4($sformatf("hold%0d", i), 1'b1, DW'(32'h1ABCD), 2'd2);
        end
        // Consumer takes the word with no requests pending: valid drops.
        b4.req_valid_i = '0;
        b4.out_ready_i = 1'b1;
        tick();
        out4("r2_done", 1'b0, DW'(32'h1ABCD), 2'd2);

        // ptr=3 with requesters 0 and 3 valid: 3 first, then wrap to 0.
        b4.req_valid_i = 4'b1001;
        #1;
        check("wrap_ready3", 64'(b4.req_ready_o), 64'b1000);
        tick();
        out4("wrap3", 1'b1, DW'(32'h23), 2'd3);
        b4.req_valid_i = 4'b0001;
        #1;
        check("wrap_ready0", 64'(b4.req_ready_o), 64'b0001);
        tick();
        out4("wrap0", 1'b1, DW'(32'h20), 2'd0);
        b4.req_valid_i = '0;
        tick();
        check("wrap_idle", 64'(b4.out_valid_o), 64'h0);

        // Clock-enable freeze mid-stream (ptr=1).
        b4.req_valid_i = 4'b1111;
        for (int k = 0; k < 4; k++) set4(k, DW'(32'h10 + k));
        tick();
        out4("cke_pre", 1'b1, DW'(32'h11), 2'd1);
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("cke%0d_ready", i), 64'(b4.req_ready_o), 64'h0);
            tick();
            out4($sformatf("cke%0d", i), 1'b1, DW'(32'h11), 2'd1);
        end
        cke = 1'b1;
        #1;
        check("cke_resume_ready", 64'(b4.req_ready_o), 64'b0100);
        tick();
        out4("cke_resume2", 1'b1, DW'(32'h12), 2'd2);
        tick();
        out4("cke_resume3", 1'b1, DW'(32'h13), 2'd3);
        b4.req_valid_i = '0;
        tick();
        check("cke_idle", 64'(b4.out_valid_o), 64'h0);

        // Asynchronous reset while FULL (ptr=0 -> requester 0 loads 0x155, ptr=1).
        b4.req_valid_i = 4'b0001;
        set4(0, DW'(32'h155));
        b4.out_ready_i = 1'b0;
        tick();
        out4("pre_rst", 1'b1, DW'(32'h155), 2'd0);
        b4.req_valid_i = 4'b0110;
        set4(1, DW'(32'h41));
        set4(2, DW'(32'h42));
        #1;
        check("pre_rst_ready", 64'(b4.req_ready_o), 64'h0);
        #1;
        arst_n = 1'b0;
        #1;
        out4("arst", 1'b0, '0, 2'd0);
        check("arst_ready", 64'(b4.req_ready_o), 64'h0);
        #1;
        arst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(b4.req_ready_o), 64'b0010);
        tick();
        out4("post_rst", 1'b1, DW'(32'h41), 2'd1);
        b4.req_valid_i = '0;
        b4.out_ready_i = 1'b1;
        tick();

        // N_REQ=3 build: ids 0,1,2,0 and the ready one-hot never reaches bit 3.
        b3.req_valid_i = 3'b111;
        for (int k = 0; k < 3; k++) set3(k, DW'(32'h30 + k));
        b3.out_ready_i = 1'b1;
        #1;
        check("n3_ready_init", 64'(b3.req_ready_o), 64'b001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("n3_%0d_id", i),   64'(b3.out_id_o),   64'(i % 3));
            check($sformatf("n3_%0d_data", i), 64'(b3.out_data_o), 64'(32'h30 + (i % 3)));
            check($sformatf("n3_%0d_ready", i), 64'(b3.req_ready_o), 64'(3'b001 << ((i + 1) % 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
